console_out_arbiter: RTL
========================

# console_out_arbiter

Shares the single CONSOLE_OUT byte channel of the Wrapper between N_REQ byte producers, such as the processor's memory-mapped console port and a debug/monitor source. It uses round-robin arbitration with message-level locking, so that bytes of different messages never interleave. A registered output stage drives CONSOLE_OUT/CONSOLE_OUT_valid and obeys CONSOLE_OUT_ready from the UART side.

## Interface
- N_REQ, 3: number of requesters (2..8).
- EOM_CHAR, 8'h0D: byte that terminates a message and releases the lock.
- IDLE_TIMEOUT, 64: cycles the granted requester may hold valid low before the lock is revoked. 0 disables the timeout.

- CLK  in  1  clock; all state changes on the rising edge.
- RESETn  in  1  one clock; reset is asynchronous and active-low.
- REQ_DATA  in  8*N_REQ  byte from requester i, at bits [8i+7:8i].
- REQ_valid  in  N_REQ  requester i has a byte on REQ_DATA.
- REQ_ready  out  N_REQ  byte of requester i is accepted this cycle when valid and ready are both high.
- GRANT  out  N_REQ  one-hot lock owner; all zero when idle.
- CONSOLE_OUT  out  8  output byte.
- CONSOLE_OUT_valid  out  1  CONSOLE_OUT holds a byte.
- CONSOLE_OUT_ready  in  1  sink accepts the byte this cycle when valid is also high.

## Operation
- **States:** IDLE and LOCKED.
- **IDLE:**
  - GRANT is zero and REQ_ready is zero.
  - If any REQ_valid is high, select the first valid requester searching from index ptr upward with wrap. Register it as GRANT, go to LOCKED, and set ptr = winner+1 mod N_REQ.
- **LOCKED with owner g:**
  - REQ_ready[g] = ~CONSOLE_OUT_valid | CONSOLE_OUT_ready. All other REQ_ready bits are 0.
  - On a transfer (REQ_valid[g] & REQ_ready[g]), load CONSOLE_OUT with the byte and set CONSOLE_OUT_valid = 1.
  - If the transferred byte equals EOM_CHAR, go to IDLE next cycle. The byte still drains through the output register.
  - Timeout counter:
    - Cleared on entering LOCKED and on every cycle REQ_valid[g] is high.
    - Increments while REQ_valid[g] is low.
    - When it reaches IDLE_TIMEOUT, go to IDLE without a transfer.
    - Counter width is clog2(IDLE_TIMEOUT+1) and it saturates, with no wrap.
- **Output register:**
  - Clears CONSOLE_OUT_valid on CONSOLE_OUT_ready when no new byte loads the same cycle.
  - Load and drain in the same cycle keeps valid = 1 with the new byte.
  - CONSOLE_OUT holds its value while valid is high and ready is low.
- Non-granted requesters are never acknowledged. Their REQ_valid/REQ_DATA must stay stable until they are granted; this is the producer's obligation.
- **Reset (RESETn low, at any time including mid-message):**
  - Immediately: state IDLE, GRANT = 0, REQ_ready = 0, CONSOLE_OUT_valid = 0, CONSOLE_OUT = 8'h00, ptr = 0, counter = 0.
  - A byte held in the output register is discarded.

## Timing
- REQ_valid[i] rises in IDLE at edge t, giving GRANT[i] = 1 and REQ_ready[i] = 1 after t+1 (output empty). The first byte is transferred in cycle t+1, and CONSOLE_OUT_valid = 1 after t+2.
- Throughput while locked is 1 byte/cycle when CONSOLE_OUT_ready is held high.
- CONSOLE_OUT_ready low stalls REQ_ready[g] combinationally in the same cycle. No byte is dropped or duplicated.
- After EOM is transferred at cycle t: IDLE at t+1, the next grant is registered at t+2. This gives one idle arbitration cycle between messages.
- Timeout: the owner drops valid at cycle t. The lock is released after IDLE_TIMEOUT full low cycles, i.e. IDLE at t+IDLE_TIMEOUT+1.
- Simultaneous requests in IDLE are resolved by ptr. A requester asserting during LOCKED waits for release.
- The EOM byte and a timeout cannot coincide, because a transfer needs valid high.

## Test plan
- **Single message:** with N_REQ=3 and ready held at 1, requester 1 sends "Hi\r" (8'h48, 8'h69, 8'h0D).
  - GRANT = 3'b010 one cycle after valid.
  - CONSOLE_OUT carries 48, 69, 0D on consecutive cycles.
  - GRANT returns to 0 the cycle after 0D is accepted.
- **Round robin:** requesters 0, 1 and 2 each hold a 2-byte message ending in 0D, all asserted together after reset.
  - Output order is messages 0, 1, 2, with no interleaved bytes.
  - Repeating the stimulus gives the same order, confirming that ptr wraps to 0.
- **Back-pressure:** ready low for 5 cycles mid-message.
  - CONSOLE_OUT is stable and CONSOLE_OUT_valid stays 1.
  - REQ_ready[g] = 0 during the stall.
  - After ready rises, the byte sequence is intact with no duplicates.
- **Timeout:** IDLE_TIMEOUT=4, requester 0 sends 8'h41 then drops valid while requester 2 is waiting.
  - GRANT switches to 3'b100 exactly 4 low cycles later plus one arbitration cycle.
- **Reset mid-message:** RESETn pulses low with CONSOLE_OUT_valid = 1 and GRANT = 3'b001.
  - All outputs go to 0 asynchronously.
  - After release, the first arbitration starts at requester 0.
- **Non-owner isolation:** requester 2 toggles REQ_DATA while requester 1 owns the lock.
  - REQ_ready[2] stays 0.
  - No requester-2 byte appears until requester 1's EOM is accepted.

Source files
------------

// File: rtl/console_out_arbiter_if.sv
// Producer/sink bundle for the console output arbiter.
// master = producers and UART sink, slave = arbiter.
interface console_out_arbiter_if #(
    parameter int N_REQ = 3
);
    logic [8*N_REQ-1:0] REQ_DATA;
    logic [N_REQ-1:0]   REQ_valid;
    logic [N_REQ-1:0]   REQ_ready;
    logic [N_REQ-1:0]   GRANT;
    logic [7:0]         CONSOLE_OUT;
    logic               CONSOLE_OUT_valid;
    logic               CONSOLE_OUT_ready;

    modport master (
        output REQ_DATA,
        output REQ_valid,
        output CONSOLE_OUT_ready,
        input  REQ_ready,
        input  GRANT,
        input  CONSOLE_OUT,
        input  CONSOLE_OUT_valid
    );

    modport slave (
        input  REQ_DATA,
        input  REQ_valid,
        input  CONSOLE_OUT_ready,
        output REQ_ready,
        output GRANT,
        output CONSOLE_OUT,
        output CONSOLE_OUT_valid
    );
endinterface

// File: rtl/console_out_arbiter.sv
// Round-robin, message-locked arbiter sharing one console byte
// channel between N_REQ producers, with a registered output stage.
module console_out_arbiter #(
    parameter int         N_REQ        = 3,
    parameter logic [7:0] EOM_CHAR     = 8'h0D,
    parameter int         IDLE_TIMEOUT = 64
) (
    input  logic                  CLK,
    input  logic                  RESETn,
    console_out_arbiter_if.slave  bus
);
    localparam int IW  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int IW1 = IW + 1;
    localparam int CW  = (IDLE_TIMEOUT > 0) ?
                         $clog2(IDLE_TIMEOUT + 1) : 1;
    localparam logic [CW-1:0]  TMAX = CW'(IDLE_TIMEOUT);
    localparam logic [IW1-1:0] NR   = IW1'(N_REQ);
    localparam logic [IW-1:0]  LAST = IW'(N_REQ - 1);

    typedef enum logic {
        IDLE,
        LOCKED
    } state_t;

    state_t           state_q, state_d;
    logic [N_REQ-1:0] grant_q, grant_d;
    logic [IW-1:0]    own_q, own_d;
    logic [IW-1:0]    ptr_q, ptr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [7:0]       dat_q, dat_d;
    logic             vld_q, vld_d;

    logic [7:0]       bytes [N_REQ];
    logic             found;
    logic [IW-1:0]    win;
    logic [IW1-1:0]   idx;
    logic             locked;
    logic             out_free;
    logic             tmo;
    logic             xfer;
    logic             eom;

    for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
        assign bytes[i] = bus.REQ_DATA[8*i +: 8];
    end

    // First valid requester at or after ptr, with wrap.
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = {1'b0, ptr_q} + IW1'(k);
            if (idx >= NR) idx = idx - NR;
            if (!found && bus.REQ_valid[idx[IW-1:0]]) begin
                found = 1'b1;
                win   = idx[IW-1:0];
            end
        end
    end

    assign locked   = (state_q == LOCKED);
    assign out_free = !vld_q || bus.CONSOLE_OUT_ready;
    // A revoked lock must not sneak in a last byte.
    assign tmo      = (IDLE_TIMEOUT != 0) && (cnt_q == TMAX);
    assign xfer     = locked && !tmo && out_free &&
                      bus.REQ_valid[own_q];
    assign eom      = (bytes[own_q] == EOM_CHAR);

    assign bus.REQ_ready = (locked && !tmo && out_free) ?
                           grant_q : '0;
    assign bus.GRANT             = grant_q;
    assign bus.CONSOLE_OUT       = dat_q;
    assign bus.CONSOLE_OUT_valid = vld_q;

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        own_d   = own_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        dat_d   = dat_q;
        vld_d   = vld_q;

        if (xfer) begin
            dat_d = bytes[own_q];
            vld_d = 1'b1;
        end else if (bus.CONSOLE_OUT_ready) begin
            vld_d = 1'b0;
        end

        unique case (state_q)
            IDLE: begin
                if (found) begin
                    state_d = LOCKED;
                    own_d   = win;
                    grant_d = N_REQ'(1) << win;
                    ptr_d   = (win == LAST) ? '0 : win + 1'b1;
                    cnt_d   = '0;
                end
            end
            LOCKED: begin
                if (bus.REQ_valid[own_q]) begin
                    cnt_d = '0;
                end else if (IDLE_TIMEOUT != 0 &&
                             cnt_q != TMAX) begin
                    cnt_d = cnt_q + 1'b1;
                end
                if (tmo || (xfer && eom)) begin
                    state_d = IDLE;
                    grant_d = '0;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            state_q <= IDLE;
            grant_q <= '0;
            own_q   <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
            dat_q   <= 8'h00;
            vld_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            own_q   <= own_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            dat_q   <= dat_d;
            vld_q   <= vld_d;
        end
    end
endmodule
